// File: rtl/pong_pixel_generator.sv
// pong_pixel_generator: one-paddle Pong game driven by the CRT timing
// controller. Game state advances once per frame (falling edge of vsync),
// and the registered 8-bit RGB output (3R/3G/2B) draws the ball and paddle.
// Optional build macro PONG_SCORE_EN adds a saturating 4-bit MissCount output;
// at 15 misses the game stays in SERVE until Reset.
module pong_pixel_generator #(
  parameter int ResolutionSize = 10,
  parameter int BallSize       = 8,
  parameter int PaddleWidth    = 8,
  parameter int PaddleHeight   = 48,
  parameter int PaddleX        = 16,
  parameter int PaddleStep     = 4,
  parameter int BallStep       = 2,
  parameter int ServeFrames    = 60
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [ResolutionSize-1:0] Xresolution,
  input  logic [ResolutionSize-1:0] Yresolution,
  input  logic [ResolutionSize-1:0] xpos,
  input  logic [ResolutionSize-1:0] ypos,
  input  logic                      vsync,
  input  logic                      Up,
  input  logic                      Down,
  output logic [2:0]                Red,
  output logic [2:0]                Green,
  output logic [1:0]                Blue,
  output logic                      Missed
`ifdef PONG_SCORE_EN
  ,
  output logic [3:0]                MissCount
`endif
);

  localparam int W    = ResolutionSize;
  localparam int WE   = ResolutionSize + 1;
  localparam int CntW = (ServeFrames > 1) ? $clog2(ServeFrames) : 1;

  // Geometry constants widened by one bit so sums never wrap.
  localparam logic [WE-1:0]   BALL_SZ   = WE'(BallSize);
  localparam logic [WE-1:0]   BALL_STEP = WE'(BallStep);
  localparam logic [WE-1:0]   PAD_X     = WE'(PaddleX);
  localparam logic [WE-1:0]   PAD_W     = WE'(PaddleWidth);
  localparam logic [WE-1:0]   PAD_H     = WE'(PaddleHeight);
  localparam logic [WE-1:0]   PAD_STEP  = WE'(PaddleStep);
  localparam logic [WE-1:0]   PAD_END   = PAD_X + PAD_W;
  localparam logic [CntW-1:0] LAST_CNT  = CntW'(ServeFrames - 1);

  typedef enum logic {SERVE, PLAY} state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            vsync_dly_q, vsync_dly_d;
  logic [W-1:0]    ball_x_q, ball_x_d;
  logic [W-1:0]    ball_y_q, ball_y_d;
  logic [W-1:0]    paddle_y_q, paddle_y_d;
  logic            dx_left_q, dx_left_d;
  logic            dy_down_q, dy_down_d;
  logic            missed_q, missed_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            game_over;

  logic [WE-1:0] bx, by, py, xres, yres, xe, ye;
  logic          frame_tick, hit, miss, right_wall, top_wall, bottom_wall;
  logic          serve_done, in_ball, in_paddle;

  assign bx   = {1'b0, ball_x_q};
  assign by   = {1'b0, ball_y_q};
  assign py   = {1'b0, paddle_y_q};
  assign xres = {1'b0, Xresolution};
  assign yres = {1'b0, Yresolution};
  assign xe   = {1'b0, xpos};
  assign ye   = {1'b0, ypos};

  assign frame_tick  = vsync_dly_q & ~vsync;
  assign hit         = dx_left_q && (bx <= PAD_END) && (bx + BALL_SZ > PAD_X) &&
                       (by + BALL_SZ > py) && (by < py + PAD_H);
  assign miss        = dx_left_q && !hit && (bx < BALL_STEP);
  assign right_wall  = !dx_left_q && (bx + BALL_SZ + BALL_STEP > xres);
  assign top_wall    = !dy_down_q && (by < BALL_STEP);
  assign bottom_wall = dy_down_q && (by + BALL_SZ + BALL_STEP > yres);
  assign serve_done  = (cnt_q == LAST_CNT) && !game_over;

`ifdef PONG_SCORE_EN
  logic [3:0] miss_cnt_q, miss_cnt_d;
  assign game_over = (miss_cnt_q == 4'hF);
  assign MissCount = miss_cnt_q;

  // Miss counter saturates at 15, which also freezes the game in SERVE.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (missed_d && !game_over) miss_cnt_d = miss_cnt_q + 4'd1;
  end

  // Miss counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) miss_cnt_q <= '0;
    else       miss_cnt_q <= miss_cnt_d;
  end
`else
  assign game_over = 1'b0;
`endif

  // State and game registers; reset re-centres the ball and paddle at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= SERVE;
      cnt_q       <= '0;
      vsync_dly_q <= 1'b1;
      ball_x_q    <= Xresolution >> 1;
      ball_y_q    <= Yresolution >> 1;
      paddle_y_q  <= (Yresolution - PAD_H[W-1:0]) >> 1;
      dx_left_q   <= 1'b1;
      dy_down_q   <= 1'b1;
      missed_q    <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vsync_dly_q <= vsync_dly_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      paddle_y_q  <= paddle_y_d;
      dx_left_q   <= dx_left_d;
      dy_down_q   <= dy_down_d;
      missed_q    <= missed_d;
      rgb_q       <= rgb_d;
    end
  end

  // Next-state: serve delay expires into PLAY, a miss returns to SERVE.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        SERVE:   if (serve_done) state_d = PLAY;
        PLAY:    if (miss) state_d = SERVE;
        default: state_d = SERVE;
      endcase
    end
  end

  // Per-frame game update: serve counter, paddle motion, ball motion.
  always_comb begin
    vsync_dly_d = vsync;
    cnt_d       = cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    paddle_y_d  = paddle_y_q;
    dx_left_d   = dx_left_q;
    dy_down_d   = dy_down_q;
    if (frame_tick) begin
      if (Up && !Down) begin
        if (py < PAD_STEP) paddle_y_d = '0;
        else               paddle_y_d = paddle_y_q - PAD_STEP[W-1:0];
      end else if (Down && !Up) begin
        if (py + PAD_STEP > yres - PAD_H) paddle_y_d = Yresolution - PAD_H[W-1:0];
        else                              paddle_y_d = paddle_y_q + PAD_STEP[W-1:0];
      end
      if (state_q == SERVE) begin
        if (cnt_q == LAST_CNT) begin
          if (!game_over) begin
            cnt_d     = '0;
            dx_left_d = 1'b1;
            dy_down_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (top_wall) begin
          ball_y_d  = '0;
          dy_down_d = 1'b1;
        end else if (bottom_wall) begin
          ball_y_d  = Yresolution - BALL_SZ[W-1:0];
          dy_down_d = 1'b0;
        end else if (dy_down_q) begin
          ball_y_d = ball_y_q + BALL_STEP[W-1:0];
        end else begin
          ball_y_d = ball_y_q - BALL_STEP[W-1:0];
        end
        if (hit) begin
          ball_x_d  = PAD_END[W-1:0];
          dx_left_d = 1'b0;
        end else if (miss) begin
          ball_x_d = Xresolution >> 1;
          ball_y_d = Yresolution >> 1;
        end else if (right_wall) begin
          ball_x_d  = Xresolution - BALL_SZ[W-1:0];
          dx_left_d = 1'b1;
        end else if (dx_left_q) begin
          ball_x_d = ball_x_q - BALL_STEP[W-1:0];
        end else begin
          ball_x_d = ball_x_q + BALL_STEP[W-1:0];
        end
      end
    end
  end

  // Outputs: miss pulse and pixel colour, both from pre-update positions.
  always_comb begin
    missed_d  = frame_tick && (state_q == PLAY) && miss;
    in_ball   = (xe >= bx) && (xe < bx + BALL_SZ) && (ye >= by) && (ye < by + BALL_SZ);
    in_paddle = (xe >= PAD_X) && (xe < PAD_END) && (ye >= py) && (ye < py + PAD_H);
    rgb_d     = 8'h00;
    if (xpos >= Xresolution || ypos >= Yresolution) rgb_d = 8'h00;
    else if (in_ball)                               rgb_d = 8'b111_111_11;
    else if (in_paddle)                             rgb_d = 8'b000_111_00;
  end

  assign Red    = rgb_q[7:5];
  assign Green  = rgb_q[4:2];
  assign Blue   = rgb_q[1:0];
  assign Missed = missed_q;

endmodule

// File: tb/tb_pong_pixel_generator.sv
// Directed bench for pong_pixel_generator using a small 64x48 playfield.
// Ball and paddle positions are observed only through the RGB output.
module tb_pong_pixel_generator;

  logic       Clock = 1'b0;
  logic       Reset, vsync, Up, Down;
  logic [9:0] Xresolution, Yresolution, xpos, ypos;
  logic [2:0] Red, Green;
  logic [1:0] Blue;
  logic       Missed;
`ifdef PONG_SCORE_EN
  logic [3:0] MissCount;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 Clock = ~Clock;

  pong_pixel_generator #(
    .ResolutionSize(10), .BallSize(4), .PaddleWidth(2), .PaddleHeight(8),
    .PaddleX(4), .PaddleStep(2), .BallStep(2), .ServeFrames(3)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Xresolution(Xresolution), .Yresolution(Yresolution),
    .xpos(xpos), .ypos(ypos), .vsync(vsync), .Up(Up), .Down(Down),
    .Red(Red), .Green(Green), .Blue(Blue), .Missed(Missed)
`ifdef PONG_SCORE_EN
    , .MissCount(MissCount)
`endif
  );

  // One pixel lookup: drive coordinates, read the registered colour a Clock later.
  task automatic probe(input int x, input int y, output logic [7:0] rgb);
    @(negedge Clock);
    xpos = 10'(x);
    ypos = 10'(y);
    @(posedge Clock);
    #1 rgb = {Red, Green, Blue};
  endtask

  // Locate the ball's top-left corner by grid search then edge refinement.
  task automatic find_ball(output int fx, output int fy);
    logic [7:0] rgb;
    bit go;
    fx = -1;
    fy = -1;
    for (int y = 0; y < 48 && fx < 0; y += 4)
      for (int x = 0; x < 64 && fx < 0; x += 4) begin
        probe(x, y, rgb);
        if (rgb == 8'hFF) begin
          fx = x;
          fy = y;
        end
      end
    if (fx >= 0) begin
      go = 1'b1;
      while (go && fx > 0) begin
        probe(fx - 1, fy, rgb);
        if (rgb == 8'hFF) fx--; else go = 1'b0;
      end
      go = 1'b1;
      while (go && fy > 0) begin
        probe(fx, fy - 1, rgb);
        if (rgb == 8'hFF) fy--; else go = 1'b0;
      end
    end
  endtask

  // Measure the paddle's top row and height along column x=5.
  task automatic find_paddle(output int top, output int height);
    logic [7:0] rgb;
    top    = -1;
    height = 0;
    for (int y = 0; y < 48; y++) begin
      probe(5, y, rgb);
      if (rgb == 8'h1C) begin
        if (top < 0) top = y;
        height++;
      end
    end
  endtask

  // One frame: vsync low for 4 Clocks then high; counts Missed-high cycles.
  task automatic do_tick(output int pulses);
    pulses = 0;
    @(negedge Clock);
    vsync = 1'b0;
    repeat (4) begin
      @(posedge Clock);
      #1 if (Missed === 1'b1) pulses++;
    end
    @(negedge Clock);
    vsync = 1'b1;
    @(posedge Clock);
    #1 if (Missed === 1'b1) pulses++;
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    vsync = 1'b1;
    Up    = 1'b0;
    Down  = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rgb;
    int bx, by, pt, ph;
    repeat (3) @(posedge Clock);
    #1;
    compared++;
    if ({Red, Green, Blue} !== 8'h00 || Missed !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got rgb=%h missed=%b want rgb=00 missed=0", {Red, Green, Blue}, Missed);
    end
`ifdef PONG_SCORE_EN
    compared++;
    if (MissCount !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_misscount got %0d want 0", MissCount);
    end
`endif
    @(negedge Clock);
    Reset = 1'b0;
    find_ball(bx, by);
    compared++;
    if (bx != 32 || by != 24) begin
      mismatched++;
      $display("[TB] FAIL reset_ball got (%0d,%0d) want (32,24)", bx, by);
    end
    find_paddle(pt, ph);
    compared++;
    if (pt != 20 || ph != 8) begin
      mismatched++;
      $display("[TB] FAIL reset_paddle got top=%0d h=%0d want top=20 h=8", pt, ph);
    end
    probe(70, 10, rgb);
    compared++;
    if (rgb !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL blank_x got %h want 00", rgb);
    end
    probe(10, 50, rgb);
    compared++;
    if (rgb !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL blank_y got %h want 00", rgb);
    end
  endtask

  // Three serve frames hold the ball at centre; the fourth moves it.
  task automatic test_serve(input string tag);
    int ex[4] = '{32, 32, 32, 30};
    int ey[4] = '{24, 24, 24, 26};
    int p, bx, by;
    for (int i = 0; i < 4; i++) begin
      do_tick(p);
      find_ball(bx, by);
      compared++;
      if (bx != ex[i] || by != ey[i] || p != 0) begin
        mismatched++;
        $display("[TB] FAIL %s_tick%0d got (%0d,%0d) pulses=%0d want (%0d,%0d) pulses=0",
                 tag, i + 1, bx, by, p, ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_bottom_bounce();
    int ex[3] = '{12, 10, 8};
    int ey[3] = '{44, 44, 42};
    int p, bx, by;
    logic [7:0] rgb;
    repeat (8) do_tick(p);
    for (int i = 0; i < 3; i++) begin
      do_tick(p);
      find_ball(bx, by);
      compared++;
      if (bx != ex[i] || by != ey[i]) begin
        mismatched++;
        $display("[TB] FAIL bottom_bounce%0d got (%0d,%0d) want (%0d,%0d)", i, bx, by, ex[i], ey[i]);
      end
    end
    probe(11, 45, rgb);
    compared++;
    if (rgb !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL ball_pixel got %h want ff", rgb);
    end
    probe(4, 22, rgb);
    compared++;
    if (rgb !== 8'h1C) begin
      mismatched++;
      $display("[TB] FAIL paddle_pixel got %h want 1c", rgb);
    end
    probe(6, 22, rgb);
    compared++;
    if (rgb !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL background_pixel got %h want 00", rgb);
    end
  endtask

  task automatic test_miss();
    int ex[5] = '{6, 4, 2, 0, 32};
    int ey[5] = '{40, 38, 36, 34, 24};
    int ep[5] = '{0, 0, 0, 0, 1};
    int p, bx, by;
    for (int i = 0; i < 5; i++) begin
      do_tick(p);
      find_ball(bx, by);
      compared++;
      if (bx != ex[i] || by != ey[i] || p != ep[i]) begin
        mismatched++;
        $display("[TB] FAIL miss_step%0d got (%0d,%0d) pulses=%0d want (%0d,%0d) pulses=%0d",
                 i, bx, by, p, ex[i], ey[i], ep[i]);
      end
    end
    do_tick(p);
    find_ball(bx, by);
    compared++;
    if (bx != 32 || by != 24) begin
      mismatched++;
      $display("[TB] FAIL miss_serve_hold got (%0d,%0d) want (32,24)", bx, by);
    end
`ifdef PONG_SCORE_EN
    compared++;
    if (MissCount !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL miss_count got %0d want 1", MissCount);
    end
`endif
  endtask

  // Asynchronous reset during serve (counter non-zero) clears everything at once.
  task automatic test_mid_reset();
    logic [7:0] rgb;
    int pt, ph;
    probe(33, 25, rgb);
    compared++;
    if (rgb !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_pixel got %h want ff", rgb);
    end
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    compared++;
    if ({Red, Green, Blue} !== 8'h00 || Missed !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset got rgb=%h missed=%b want rgb=00 missed=0", {Red, Green, Blue}, Missed);
    end
`ifdef PONG_SCORE_EN
    compared++;
    if (MissCount !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset_misscount got %0d want 0", MissCount);
    end
`endif
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    find_paddle(pt, ph);
    compared++;
    if (pt != 20) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_paddle got %0d want 20", pt);
    end
    test_serve("reserve");
  endtask

  task automatic test_paddle_hit();
    int p, bx, by, pt, ph;
    int ex[3] = '{6, 6, 8};
    int ey[3] = '{40, 38, 36};
    pulse_reset();
    Down = 1'b1;
    repeat (10) do_tick(p);
    find_paddle(pt, ph);
    compared++;
    if (pt != 40 || ph != 8) begin
      mismatched++;
      $display("[TB] FAIL paddle_down got top=%0d h=%0d want top=40 h=8", pt, ph);
    end
    repeat (5) do_tick(p);
    for (int i = 0; i < 3; i++) begin
      do_tick(p);
      find_ball(bx, by);
      compared++;
      if (bx != ex[i] || by != ey[i] || p != 0) begin
        mismatched++;
        $display("[TB] FAIL paddle_hit%0d got (%0d,%0d) pulses=%0d want (%0d,%0d) pulses=0",
                 i, bx, by, p, ex[i], ey[i]);
      end
    end
    find_paddle(pt, ph);
    compared++;
    if (pt != 40) begin
      mismatched++;
      $display("[TB] FAIL paddle_clamp_bottom got %0d want 40", pt);
    end
    Down = 1'b0;
  endtask

  task automatic test_clamp_top();
    int p, pt, ph;
    int ep[3] = '{0, 0, 2};
    pulse_reset();
    Up = 1'b1;
    repeat (10) do_tick(p);
    find_paddle(pt, ph);
    compared++;
    if (pt != 0 || ph != 8) begin
      mismatched++;
      $display("[TB] FAIL paddle_up got top=%0d h=%0d want top=0 h=8", pt, ph);
    end
    for (int i = 0; i < 3; i++) begin
      Up   = (i < 2);
      Down = (i >= 1);
      do_tick(p);
      find_paddle(pt, ph);
      compared++;
      if (pt != ep[i]) begin
        mismatched++;
        $display("[TB] FAIL paddle_clamp_top%0d got %0d want %0d", i, pt, ep[i]);
      end
    end
    Up   = 1'b0;
    Down = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    vsync       = 1'b1;
    Up          = 1'b0;
    Down        = 1'b0;
    Xresolution = 10'd64;
    Yresolution = 10'd48;
    xpos        = 10'd32;
    ypos        = 10'd24;
    $display("[TB] start");
    test_reset();
    test_serve("serve");
    test_bottom_bounce();
    test_miss();
    test_mid_reset();
    test_paddle_hit();
    test_clamp_top();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
